// File: rtl/wb_spi_bridge_if.sv
// Bus bundle between a Wishbone master, the bridge and the downstream spi_if.
// slave  : the bridge's view (Wishbone target, drives the spi_if strobes)
// master : the environment's view (bus master plus spi_if responder)
interface wb_spi_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [10:0] spi_din;
    logic        spi_cmd;
    logic        spi_wr;
    logic        spi_rd;
    logic [8:0]  spi_dout;
    logic        spi_ack;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output spi_din, spi_cmd, spi_wr, spi_rd,
        input  spi_dout, spi_ack
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  spi_din, spi_cmd, spi_wr, spi_rd,
        output spi_dout, spi_ack
    );
endinterface

// File: rtl/wb_spi_bridge.sv
// Wishbone classic slave in front of spi_if: turns bus cycles into one-cycle
// cmd/wr/rd strobes, waits for the spi_if ack with a bounded timeout, and keeps
// a config shadow plus a saturating error counter for software.
//
// state | meaning
// IDLE  | waiting for cyc&stb; local accesses are answered from here
// ISSUE | one strobe to spi_if this cycle; RX data captured at its end
// WAIT  | waiting for spi_ack, counting towards the timeout
// RESP  | one-cycle ack or err pulse on the bus
module wb_spi_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    wb_spi_bridge_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OP_CMD = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2} op_t;

    localparam logic [7:0] TC = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    op_t         r_op;
    logic [7:0]  r_cnt;
    logic [7:0]  r_errcnt;
    logic        r_last_err;
    logic [10:0] r_shadow;
    logic [10:0] r_din;
    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_err;

    logic        w_req;
    logic        w_remote;
    logic        w_take_remote;
    logic        w_take_local;
    logic        w_done_ok;
    logic        w_done_err;
    logic [31:0] w_status;
    logic        w_unused_dat;

    assign w_req    = bus.wb_cyc_i & bus.wb_stb_i;
    // CTRL/TXDATA writes and RXDATA reads have to go through spi_if
    assign w_remote = bus.wb_we_i ? (bus.wb_adr_i == 2'd0 || bus.wb_adr_i == 2'd1)
                                  : (bus.wb_adr_i == 2'd2);
    assign w_status = {r_last_err, 7'b0, r_errcnt, 5'b0, r_shadow};
    assign w_unused_dat = ^bus.wb_dat_i[31:11];

    assign bus.spi_cmd  = (r_state == S_ISSUE) && (r_op == OP_CMD);
    assign bus.spi_wr   = (r_state == S_ISSUE) && (r_op == OP_WR);
    assign bus.spi_rd   = (r_state == S_ISSUE) && (r_op == OP_RD);
    assign bus.spi_din  = r_din;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_ack_o = r_ack;
    assign bus.wb_err_o = r_err;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next state and transaction events
    always_comb begin
        w_state_nxt   = r_state;
        w_take_remote = 1'b0;
        w_take_local  = 1'b0;
        w_done_ok     = 1'b0;
        w_done_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_remote) begin
                        w_take_remote = 1'b1;
                        w_state_nxt   = S_ISSUE;
                    end else begin
                        w_take_local  = 1'b1;
                        w_state_nxt   = S_RESP;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // a dropped cycle abandons the access; the strobe is already out
                if (!bus.wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.spi_ack) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == TC) begin
                    w_done_err  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // datapath: responses, spi_if data, shadow, timeout and error bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_CMD;
            r_cnt      <= 8'd0;
            r_errcnt   <= 8'd0;
            r_last_err <= 1'b0;
            r_shadow   <= 11'd0;
            r_din      <= 11'd0;
            r_dat      <= 32'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack <= w_take_local | w_done_ok;
            r_err <= w_done_err;

            if (w_take_remote) begin
                if (!bus.wb_we_i)                r_op <= OP_RD;
                else if (bus.wb_adr_i == 2'd0)   r_op <= OP_CMD;
                else                             r_op <= OP_WR;
                if (bus.wb_we_i) r_din <= bus.wb_dat_i[10:0];
            end

            if (r_state == S_ISSUE)     r_cnt <= 8'd0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;

            if (r_state == S_ISSUE && r_op == OP_CMD) r_shadow <= r_din;
            if (r_state == S_ISSUE && r_op == OP_RD)  r_dat <= {23'b0, bus.spi_dout};

            if (w_take_local && !bus.wb_we_i) begin
                case (bus.wb_adr_i)
                    2'd0:    r_dat <= {21'b0, r_shadow};
                    2'd3:    r_dat <= w_status;
                    default: r_dat <= 32'd0;
                endcase
            end

            if (w_take_local && bus.wb_we_i && bus.wb_adr_i == 2'd3) begin
                r_errcnt   <= 8'd0;
                r_last_err <= 1'b0;
            end else if (w_done_err) begin
                r_last_err <= 1'b1;
                if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
            end else if (w_done_ok) begin
                r_last_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_spi_bridge.sv
// Directed bench for wb_spi_bridge: a transaction-level model predicts on which
// cycle each strobe/ack/err must appear and what data goes with it; a single
// compare process checks the DUT against that every cycle.
module tb_wb_spi_bridge;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_spi_bridge_if bus();
    wb_spi_bridge #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // expectation timeline (absolute cycle numbers, -1 = none)
    int          t_strb = -1;
    int          t_ack  = -1;
    int          t_err  = -1;
    int          exp_kind = 0;      // 0 cmd, 1 wr, 2 rd
    logic [10:0] exp_din = '0;
    logic [31:0] exp_dat = '0;
    bit          exp_dat_chk = 0;

    // software-visible model state
    logic [10:0] m_shadow = '0;
    logic [10:0] m_din    = '0;
    int          m_errcnt = 0;
    logic        m_last   = 1'b0;
    logic [8:0]  dout_val = '0;
    bit          ack_en   = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {m_last, 7'b0, 8'(m_errcnt), 5'b0, m_shadow};
    endfunction

    // spi_if responder: ack the cycle after any strobe when enabled
    initial begin
        logic s;
        bus.spi_ack  = 1'b0;
        bus.spi_dout = '0;
        forever begin
            @(negedge clk);
            s = bus.spi_cmd | bus.spi_wr | bus.spi_rd;
            @(posedge clk);
            #1;
            bus.spi_ack = s & ack_en;
        end
    end

    // per-cycle comparison against the expectation timeline
    always @(negedge clk) begin
        chk("wb_ack_o", 32'(bus.wb_ack_o), 32'(cyc_n == t_ack));
        chk("wb_err_o", 32'(bus.wb_err_o), 32'(cyc_n == t_err));
        chk("spi_cmd",  32'(bus.spi_cmd),  32'(cyc_n == t_strb && exp_kind == 0));
        chk("spi_wr",   32'(bus.spi_wr),   32'(cyc_n == t_strb && exp_kind == 1));
        chk("spi_rd",   32'(bus.spi_rd),   32'(cyc_n == t_strb && exp_kind == 2));
        if (cyc_n == t_strb) chk("spi_din", 32'(bus.spi_din), 32'(exp_din));
        if (cyc_n == t_ack && exp_dat_chk) chk("wb_dat_o", bus.wb_dat_o, exp_dat);
    end

    task automatic drive(input bit we, input logic [1:0] adr, input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
    endtask

    task automatic release_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // called at the start of a cycle (just after a rising edge); returns there
    task automatic access(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                          input bit ack, output logic [31:0] rd);
        bit remote;
        int off;
        remote = we ? (adr == 2'd0 || adr == 2'd1) : (adr == 2'd2);
        ack_en = ack;
        bus.spi_dout = dout_val;
        exp_dat_chk = !we;
        if (!we) begin
            case (adr)
                2'd0: exp_dat = {21'b0, m_shadow};
                2'd1: exp_dat = 32'd0;
                2'd2: exp_dat = {23'b0, dout_val};
                default: exp_dat = m_status();
            endcase
        end
        t_ack = -1;
        t_err = -1;
        if (remote) begin
            exp_kind = we ? ((adr == 2'd0) ? 0 : 1) : 2;
            if (we) m_din = dat[10:0];
            exp_din = m_din;
            if (we && adr == 2'd0) m_shadow = dat[10:0];
            t_strb = cyc_n + 1;
            if (ack) begin
                off = 3;
                t_ack = cyc_n + 3;
                m_last = 1'b0;
            end else begin
                off = 2 + T;
                t_err = cyc_n + 2 + T;
                m_last = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end else begin
            off = 1;
            t_strb = -1;
            t_ack = cyc_n + 1;
            if (we && adr == 2'd3) begin
                m_errcnt = 0;
                m_last = 1'b0;
            end
        end
        drive(we, adr, dat);
        repeat (off) @(posedge clk);
        @(negedge clk);
        rd = bus.wb_dat_o;
        @(posedge clk);
        #1;
        release_bus();
    endtask

    initial begin
        logic [31:0] rd;
        #200_000_000;
        $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc_n);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        release_bus();
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst err", 32'(bus.wb_err_o), 32'd0);
        chk("rst dat", bus.wb_dat_o, 32'd0);
        chk("rst din", 32'(bus.spi_din), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CTRL write left hanging in WAIT, then asynchronous reset
        ack_en = 0;
        exp_kind = 0;
        m_din = 11'h123;
        exp_din = m_din;
        m_shadow = 11'h123;
        t_strb = cyc_n + 1;
        drive(1'b1, 2'd0, 32'h0000_0123);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        t_strb = -1;
        m_shadow = '0;
        m_din = '0;
        m_errcnt = 0;
        m_last = 1'b0;
        #1;
        chk("async rst ack", 32'(bus.wb_ack_o), 32'd0);
        chk("async rst err", 32'(bus.wb_err_o), 32'd0);
        chk("async rst strobes", 32'({bus.spi_cmd, bus.spi_wr, bus.spi_rd}), 32'd0);
        chk("async rst din", 32'(bus.spi_din), 32'd0);
        release_bus();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b0, 2'd3, 32'd0, 1, rd);
        chk("status after rst", rd, 32'h0000_0000);

        // configuration and readback
        access(1'b1, 2'd0, 32'h0000_0405, 1, rd);
        access(1'b0, 2'd0, 32'd0, 1, rd);
        chk("ctrl readback", rd, 32'h0000_0405);

        // TX writes: acked, then timed out
        access(1'b1, 2'd1, 32'h0000_01A5, 1, rd);
        access(1'b1, 2'd1, 32'h0000_01A5, 0, rd);
        access(1'b0, 2'd3, 32'd0, 1, rd);
        chk("status after timeout", rd, 32'h8001_0405);
        access(1'b1, 2'd1, 32'h0000_035A, 1, rd);
        access(1'b0, 2'd1, 32'd0, 1, rd);
        chk("txdata read", rd, 32'h0000_0000);

        // RX reads
        dout_val = 9'h0A5;
        access(1'b0, 2'd2, 32'd0, 1, rd);
        chk("rx data", rd, 32'h0000_00A5);
        dout_val = 9'h100;
        access(1'b0, 2'd2, 32'd0, 1, rd);
        chk("rx empty", rd, 32'h0000_0100);
        access(1'b1, 2'd2, 32'hFFFF_FFFF, 1, rd);

        // abort: cycle dropped in WAIT, strobe already out, no response
        ack_en = 0;
        exp_kind = 1;
        m_din = 11'h0C3;
        exp_din = m_din;
        t_ack = -1;
        t_err = -1;
        t_strb = cyc_n + 1;
        drive(1'b1, 2'd1, 32'h0000_00C3);
        repeat (2) @(posedge clk);
        #1;
        release_bus();
        @(posedge clk);
        #1;
        access(1'b0, 2'd3, 32'd0, 1, rd);
        chk("status after abort", rd, 32'h0001_0405);

        // error counter saturation and clear
        for (int i = 0; i < 260; i++) access(1'b1, 2'd1, 32'(i), 0, rd);
        access(1'b0, 2'd3, 32'd0, 1, rd);
        chk("status saturated", rd, 32'h80FF_0405);
        access(1'b1, 2'd3, 32'd0, 1, rd);
        access(1'b0, 2'd3, 32'd0, 1, rd);
        chk("status cleared", rd, 32'h0000_0405);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_spi_bridge.md
# wb_spi_bridge

Wishbone B4 classic slave that sits directly upstream of the SPI interface block (`spi_if`) and translates bus cycles into its internal strobe protocol. It issues single-cycle `cmd`/`wr`/`rd` strobes and captures read data in the same cycle as the strobe. It waits for the registered ack, and converts a missing ack (write while TX FIFO full) into a bus error after a bounded timeout. It also keeps a shadow of the SPI configuration and a saturating error counter for software.

## Interface
- TIMEOUT, 16: cycles waited in WAIT for `spi_ack` before erroring (range 2..255).
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- wb_cyc_i  input  1  bus cycle valid
- wb_stb_i  input  1  strobe
- wb_we_i  input  1  1 = write
- wb_adr_i  input  2  word address (bus byte address bits [3:2])
- wb_dat_i  input  32  write data
- wb_dat_o  output  32  read data, registered
- wb_ack_o  output  1  normal termination, one-cycle pulse
- wb_err_o  output  1  error termination, one-cycle pulse
- spi_din  output  11  data/config to `spi_if` `din`, registered
- spi_cmd  output  1  config strobe to `spi_if`
- spi_wr  output  1  TX write strobe
- spi_rd  output  1  RX read strobe
- spi_dout  input  9  `spi_if` read data; bit8 = 1 means RX empty; valid only while `spi_rd` is high
- spi_ack  input  1  `spi_if` ack, arrives the cycle after an accepted strobe

## Operation
- Register map:
  - adr 0 CTRL: W = `{baud[10:3], endian[2], mode[1:0]}` to spi_if via `spi_cmd` and into the shadow; R = `{21'b0, shadow[10:0]}`, served locally.
  - adr 1 TXDATA: W = `{rx[10], stop[9], start[8], data[7:0]}` via `spi_wr`; R returns 0, served locally.
  - adr 2 RXDATA: R via `spi_rd`, returns `{23'b0, spi_dout[8:0]}`; W ignored, served locally.
  - adr 3 STATUS: R = `{last_err[31], 7'b0, errcnt[23:16], 5'b0, shadow[10:0]}`; any W clears errcnt and last_err.
- Local accesses complete without touching spi_if.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With `wb_cyc_i & wb_stb_i` and a remote access (W0, W1, R2): load `spi_din` from `wb_dat_i[10:0]` (writes only) and go to ISSUE.
  - With a local access: perform it, load `wb_dat_o`, and go to RESP with ack.
- ISSUE:
  - Assert exactly one of `spi_cmd`/`spi_wr`/`spi_rd` for exactly this cycle.
  - For R2, capture `spi_dout` into `wb_dat_o` at the end of this cycle.
  - For W0, update the shadow.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - `spi_ack` high: go to RESP with ack.
  - Otherwise increment the counter; counter == TIMEOUT-1 with no ack: go to RESP with err, set last_err, and increment errcnt (saturate at 255).
  - `wb_cyc_i` low: abort to IDLE with no response. The strobe has already been issued and is not retracted; errcnt is unchanged.
- RESP: assert `wb_ack_o` or `wb_err_o` (never both) for one cycle, then go to IDLE. A successful remote access clears last_err.
- A strobe to spi_if is never issued outside ISSUE, and at most once per bus cycle.

## Timing
- Reset values: state IDLE; `wb_dat_o`=0, `wb_ack_o`=0, `wb_err_o`=0, `spi_din`=0, `spi_cmd`/`spi_wr`/`spi_rd`=0, shadow=0, errcnt=0, last_err=0.
- Async reset mid-transaction returns to IDLE immediately; no response is generated.
- Cycle numbering: `wb_stb_i` is first sampled high at the end of cycle 0.
- Remote access:
  - Strobe in cycle 1, with `spi_din` stable in the same cycle.
  - `spi_ack` in cycle 2.
  - `wb_ack_o` in cycle 3. Latency 3.
- Timeout: `wb_err_o` in cycle 2+TIMEOUT.
- Local access: `wb_ack_o` in cycle 1.
- `wb_dat_o` holds its value until the next read is loaded; it is valid whenever `wb_ack_o` is high.
- IDLE does not accept a new request in the cycle of RESP. Back-to-back remote accesses therefore use 4 cycles each.
- `wb_sel_i` is not present; all accesses are full-word.

## Test plan
- Reset: assert `rst` asynchronously mid-WAIT -> all outputs 0 at once, FSM idle; STATUS read returns 0x0000_0000.
- CTRL write 0x0000_0405 with `spi_ack` returned in cycle 2 -> `spi_cmd` high in cycle 1 only, `spi_din`=0x405, `wb_ack_o` in cycle 3. Subsequent adr-0 read -> 0x0000_0405, ack in cycle 1, no strobe.
- TXDATA write 0x0000_01A5 with `spi_ack` -> `spi_wr` one cycle, `spi_din`=0x1A5, ack in cycle 3. Same write with `spi_ack` held low, TIMEOUT=16 -> `wb_err_o` in cycle 18; STATUS = 0x8001_0405.
- RXDATA read with `spi_dout`=0x0A5 during `spi_rd` -> `wb_dat_o`=0x0000_00A5. With `spi_dout`=0x100 -> `wb_dat_o`=0x0000_0100 (empty flag).
- Abort: drop `wb_cyc_i` in cycle 2 with no `spi_ack` -> no ack/err, FSM in IDLE next cycle, errcnt unchanged, next access served normally.
- 260 timed-out writes -> errcnt saturates at 0xFF. Write to adr 3 -> STATUS bits [31] and [23:16] read 0.
